// File: rtl/parking_sensor_emulator.sv
// Two-beam photo-sensor waveform generator for one car passing the lot gate.
// Produces enter, exit and balk sequences and keeps saturating tallies of completed passes.
module parking_sensor_emulator #(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               dir,
    input  logic               balk,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               clr_counts,
    output logic               outer,
    output logic               inner,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   enter_cnt,
    output logic [CNT_W-1:0]   exit_cnt
);

    // state | meaning
    // IDLE  | no pass running, both beams clear
    // PH1   | first sensor (A) blocked only
    // PH2   | both sensors blocked
    // PH3   | normal: B blocked only; balk: A blocked only
    // GAP   | both beams clear, last phase before completion
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t             state_q;
    logic               dir_q;
    logic               balk_q;
    logic [DWELL_W-1:0] reload_q;
    logic [DWELL_W-1:0] timer_q;
    logic               outer_q;
    logic               inner_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   enter_q;
    logic [CNT_W-1:0]   exit_q;
    logic [DWELL_W-1:0] dwell_m1_d;

    // A dwell of zero behaves as one cycle per phase.
    assign dwell_m1_d = (dwell == '0) ? '0 : dwell - 1'b1;

    function automatic state_t next_phase(input state_t s);
        case (s)
            PH1:     return PH2;
            PH2:     return PH3;
            PH3:     return GAP;
            default: return IDLE;
        endcase
    endfunction

    // Returns {outer, inner} for a phase, mapping A/B onto the physical beams by direction.
    function automatic logic [1:0] beams(input state_t s, input logic d, input logic b);
        logic a_lvl;
        logic b_lvl;
        a_lvl = 1'b0;
        b_lvl = 1'b0;
        case (s)
            PH1: begin a_lvl = 1'b1; b_lvl = 1'b0; end
            PH2: begin a_lvl = 1'b1; b_lvl = 1'b1; end
            PH3: begin a_lvl = b;    b_lvl = ~b;   end
            default: begin a_lvl = 1'b0; b_lvl = 1'b0; end
        endcase
        return d ? {a_lvl, b_lvl} : {b_lvl, a_lvl};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            balk_q   <= 1'b0;
            reload_q <= '0;
            timer_q  <= '0;
            outer_q  <= 1'b0;
            inner_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            enter_q  <= '0;
            exit_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q            <= PH1;
                        dir_q              <= dir;
                        balk_q             <= balk;
                        reload_q           <= dwell_m1_d;
                        timer_q            <= dwell_m1_d;
                        busy_q             <= 1'b1;
                        {outer_q, inner_q} <= beams(PH1, dir, balk);
                    end
                end
                default: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        timer_q            <= reload_q;
                        state_q            <= next_phase(state_q);
                        {outer_q, inner_q} <= beams(next_phase(state_q), dir_q, balk_q);
                        if (state_q == GAP || state_q > GAP) begin
                            busy_q <= 1'b0;
                            done_q <= (state_q == GAP);
                            if (state_q == GAP && !balk_q) begin
                                if (dir_q && enter_q != '1)
                                    enter_q <= enter_q + 1'b1;
                                if (!dir_q && exit_q != '1)
                                    exit_q <= exit_q + 1'b1;
                            end
                        end
                    end
                end
            endcase
            // Clearing wins over a completion landing on the same edge.
            if (clr_counts) begin
                enter_q <= '0;
                exit_q  <= '0;
            end
        end
    end

    assign outer     = outer_q;
    assign inner     = inner_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign enter_cnt = enter_q;
    assign exit_cnt  = exit_q;

endmodule
